// File: rtl/rr_arbiter_8_pkg.sv
// Shared widths and state encodings for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arbiter_8_decoder.sv
// Team 3-to-8 decoder with active-high enable; all outputs low when E=0.
module Decoder_3to8 (
   input  logic s0,
   input  logic s1,
   input  logic s2,
   input  logic E,
   output logic D0,
   output logic D1,
   output logic D2,
   output logic D3,
   output logic D4,
   output logic D5,
   output logic D6,
   output logic D7
);

   logic [2:0] sel;

   assign sel = {s2, s1, s0};

   assign D0 = E && (sel == 3'd0);
   assign D1 = E && (sel == 3'd1);
   assign D2 = E && (sel == 3'd2);
   assign D3 = E && (sel == 3'd3);
   assign D4 = E && (sel == 3'd4);
   assign D5 = E && (sel == 3'd5);
   assign D6 = E && (sel == 3'd6);
   assign D7 = E && (sel == 3'd7);

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter holding each grant until release or hold timeout.
// The owner-release input is named rel because release is a reserved word.
module rr_arbiter_8
   import rr_arbiter_8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             en,
   input  logic             rel,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic             timeout,
   output logic             busy
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [CNT_W-1:0] hold_cnt;
   logic [IDX_W:0]   pick;
   logic             hold_expired;

   // First set request at or after ptr, wrapping; MSB flags that one was found.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IDX_W-1:0] p);
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] cand;
      found = 1'b0;
      idx   = p;
      for (int i = 0; i < N_REQ; i++) begin
         cand = p + IDX_W'(i);
         if (!found && r[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      pick = rr_pick(req, ptr);
   end

   assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (en && pick[IDX_W]) begin
                  state     <= ST_BUSY;
                  gnt_idx   <= pick[IDX_W-1:0];
                  gnt_valid <= 1'b1;
                  hold_cnt  <= '0;
               end
            end
            ST_BUSY: begin
               // Release wins over a coincident timeout, so no pulse then.
               if (rel || hold_expired) begin
                  state     <= ST_IDLE;
                  gnt_valid <= 1'b0;
                  ptr       <= gnt_idx + IDX_W'(1);
                  hold_cnt  <= '0;
                  timeout   <= !rel;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign busy = gnt_valid;

   Decoder_3to8 u_dec (
      .s0 (gnt_idx[0]),
      .s1 (gnt_idx[1]),
      .s2 (gnt_idx[2]),
      .E  (gnt_valid),
      .D0 (gnt_onehot[0]),
      .D1 (gnt_onehot[1]),
      .D2 (gnt_onehot[2]),
      .D3 (gnt_onehot[3]),
      .D4 (gnt_onehot[4]),
      .D5 (gnt_onehot[5]),
      .D6 (gnt_onehot[6]),
      .D7 (gnt_onehot[7])
   );

endmodule
